// File: rtl/stream_split_pkg.sv
// ---------------------------------------------------------------------------
// stream_split_pkg
// Shared definitions for the lane splitter and the lane select mux:
//   state_t     - splitter FSM states (IDLE, PAR, SER)
//   MODE_PAR/SER - encoding of the splitter mode input
//   lane_idx_w  - width of a lane index for a given lane count
// ---------------------------------------------------------------------------
package stream_split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAR  = 2'd1,
        SER  = 2'd2
    } state_t;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SER = 1'b1;

    // A single lane still needs a 1-bit index so port widths never collapse to 0.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/stream_lane_select.sv
// ---------------------------------------------------------------------------
// stream_lane_select
// Combinational LANES:1 lane multiplexer. Maps a running lane counter to a
// physical lane (ascending or descending order) and returns that lane.
// Ports:
//   i_word  in  LANES*LANE_WIDTH  word holding all lanes (lane i at i*LANE_WIDTH)
//   i_cnt   in  IW                position in the emission order
//   o_data  out LANE_WIDTH        selected lane contents
//   o_lane  out IW                physical index of the selected lane
// ---------------------------------------------------------------------------
module stream_lane_select
    import stream_split_pkg::*;
#(
    parameter int LANE_WIDTH = 16,
    parameter int LANES      = 2,
    parameter int LSB_FIRST  = 1,
    localparam int IW        = lane_idx_w(LANES)
) (
    input  logic [LANES*LANE_WIDTH-1:0] i_word,
    input  logic [IW-1:0]               i_cnt,
    output logic [LANE_WIDTH-1:0]       o_data,
    output logic [IW-1:0]               o_lane
);

    logic [IW-1:0] w_sel;

    always_comb begin
        // Descending order walks from the top lane down.
        w_sel  = (LSB_FIRST != 0) ? i_cnt : (IW'(LANES - 1) - i_cnt);
        o_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_sel == IW'(i)) begin
                o_data = i_word[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign o_lane = w_sel;

endmodule

// File: rtl/stream_lane_splitter.sv
// ---------------------------------------------------------------------------
// stream_lane_splitter
// Accepts one LANES*LANE_WIDTH word per valid/ready handshake and delivers it
// either all at once on the parallel port or one lane per handshake on the
// serial port. A new word may be accepted in the same cycle the held word
// completes, giving 1 word/cycle (parallel) or 1 word per LANES cycles (serial).
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   mode                0 = parallel, 1 = serial; sampled on accept only
//   s_valid/s_ready/s_data   input word stream
//   p_valid/p_ready/p_data   parallel output (all lanes)
//   m_valid/m_ready/m_data   serial output, with m_lane index and m_last flag
//   word_count          number of completed words, wrapping
//   busy                a word is currently held
// ---------------------------------------------------------------------------
module stream_lane_splitter
    import stream_split_pkg::*;
#(
    parameter int LANE_WIDTH  = 16,
    parameter int LANES       = 2,
    parameter int LSB_FIRST   = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             mode,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [LANES*LANE_WIDTH-1:0]      s_data,
    output logic                             p_valid,
    input  logic                             p_ready,
    output logic [LANES*LANE_WIDTH-1:0]      p_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [LANE_WIDTH-1:0]            m_data,
    output logic [lane_idx_w(LANES)-1:0]     m_lane,
    output logic                             m_last,
    output logic [COUNT_WIDTH-1:0]           word_count,
    output logic                             busy
);

    localparam int IW = lane_idx_w(LANES);
    localparam int WW = LANES * LANE_WIDTH;

    state_t                  r_state;
    logic [WW-1:0]           r_sword;
    logic [WW-1:0]           r_pdata;
    logic [IW-1:0]           r_cnt;
    logic [LANE_WIDTH-1:0]   r_mdata;
    logic [IW-1:0]           r_mlane;
    logic [COUNT_WIDTH-1:0]  r_count;

    logic                    w_last;
    logic                    w_complete;
    logic                    w_accept;
    logic [WW-1:0]           w_sel_word;
    logic [IW-1:0]           w_sel_cnt;
    logic [LANE_WIDTH-1:0]   w_sel_data;
    logic [IW-1:0]           w_sel_lane;

    assign w_last     = (r_state == SER) && (r_cnt == IW'(LANES - 1));
    assign w_complete = ((r_state == PAR) && p_ready) || (w_last && m_ready);
    assign s_ready    = (r_state == IDLE) || w_complete;
    assign w_accept   = s_valid && s_ready;

    // The serial lane registers are loaded one step ahead: on accept they take
    // the first lane of the incoming word, otherwise the lane after r_cnt.
    assign w_sel_word = w_accept ? s_data : r_sword;
    assign w_sel_cnt  = w_accept ? '0 : (r_cnt + IW'(1));

    stream_lane_select #(
        .LANE_WIDTH (LANE_WIDTH),
        .LANES      (LANES),
        .LSB_FIRST  (LSB_FIRST)
    ) u_lane_select (
        .i_word (w_sel_word),
        .i_cnt  (w_sel_cnt),
        .o_data (w_sel_data),
        .o_lane (w_sel_lane)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pdata <= '0;
            r_mdata <= '0;
            r_mlane <= '0;
            r_count <= '0;
        end else begin
            if (w_complete) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
            if (w_accept) begin
                r_cnt <= '0;
                if (mode == MODE_SER) begin
                    r_state <= SER;
                    r_mdata <= w_sel_data;
                    r_mlane <= w_sel_lane;
                end else begin
                    r_state <= PAR;
                    r_pdata <= s_data;
                end
            end else if (w_complete) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if ((r_state == SER) && m_ready) begin
                r_cnt   <= r_cnt + IW'(1);
                r_mdata <= w_sel_data;
                r_mlane <= w_sel_lane;
            end
        end
    end

    // Serial word store needs no reset: it is only read while in SER.
    always_ff @(posedge clock) begin
        if (w_accept && (mode == MODE_SER)) begin
            r_sword <= s_data;
        end
    end

    assign p_valid    = (r_state == PAR);
    assign p_data     = r_pdata;
    assign m_valid    = (r_state == SER);
    assign m_data     = r_mdata;
    assign m_lane     = r_mlane;
    assign m_last     = w_last;
    assign word_count = r_count;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_stream_lane_splitter.sv
module tb_stream_lane_splitter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mode, s_valid, p_ready, m_ready;
    logic [31:0] s_data [2];

    wire  [1:0]  s_ready, p_valid, m_valid, m_last, busy;
    wire  [31:0] p_data0, p_data1;
    wire  [15:0] m_data0;
    wire  [7:0]  m_data1;
    wire         m_lane0;
    wire  [1:0]  m_lane1;
    wire  [3:0]  wc0;
    wire  [15:0] wc1;

    always #5 clock = ~clock;

    // dut 0: 2 x 16, ascending, 4-bit counter; dut 1: 4 x 8, descending
    stream_lane_splitter #(.LANE_WIDTH(16), .LANES(2), .LSB_FIRST(1), .COUNT_WIDTH(4)) u_dut0 (
        .clock(clock), .reset(reset), .mode(mode[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .p_valid(p_valid[0]), .p_ready(p_ready[0]), .p_data(p_data0),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data0), .m_lane(m_lane0),
        .m_last(m_last[0]), .word_count(wc0), .busy(busy[0]));

    stream_lane_splitter #(.LANE_WIDTH(8), .LANES(4), .LSB_FIRST(0), .COUNT_WIDTH(16)) u_dut1 (
        .clock(clock), .reset(reset), .mode(mode[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .p_valid(p_valid[1]), .p_ready(p_ready[1]), .p_data(p_data1),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data1), .m_lane(m_lane1),
        .m_last(m_last[1]), .word_count(wc1), .busy(busy[1]));

    function automatic int nl(input int d);   return (d == 0) ? 2 : 4;   endfunction
    function automatic int nw(input int d);   return (d == 0) ? 16 : 8;  endfunction
    function automatic int lsbf(input int d); return (d == 0) ? 1 : 0;   endfunction
    function automatic int cw(input int d);   return (d == 0) ? 4 : 16;  endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 25) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a held word, its delivery mode, and how many lanes
    // have been handed over so far.
    bit          held  [2];
    bit          ser   [2];
    logic [31:0] word  [2];
    logic [31:0] pd    [2];
    logic [31:0] md    [2];
    int          ml    [2];
    int          done  [2];
    int          nwords[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            held[d] = 0; ser[d] = 0; word[d] = '0; pd[d] = '0;
            md[d] = '0; ml[d] = 0; done[d] = 0; nwords[d] = 0;
        end
    endtask

    task automatic check_dut(input int d);
        bit pv, mv, last, sr;
        int k;
        logic [31:0] gpd, gmd, gml, gwc, mask;
        pv   = held[d] && !ser[d];
        mv   = held[d] && ser[d];
        last = mv && (done[d] == nl(d) - 1);
        if (mv) begin
            k     = (lsbf(d) != 0) ? done[d] : (nl(d) - 1 - done[d]);
            mask  = (32'd1 << nw(d)) - 32'd1;
            md[d] = (word[d] >> (k * nw(d))) & mask;
            ml[d] = k;
        end
        sr = !held[d] || (pv && p_ready[d]) || (last && m_ready[d]);

        gpd = (d == 0) ? p_data0 : p_data1;
        gmd = (d == 0) ? {16'b0, m_data0} : {24'b0, m_data1};
        gml = (d == 0) ? {31'b0, m_lane0} : {30'b0, m_lane1};
        gwc = (d == 0) ? {28'b0, wc0} : {16'b0, wc1};

        chk($sformatf("d%0d_s_ready", d), s_ready[d], sr);
        chk($sformatf("d%0d_p_valid", d), p_valid[d], pv);
        chk($sformatf("d%0d_m_valid", d), m_valid[d], mv);
        chk($sformatf("d%0d_m_last", d),  m_last[d],  last);
        chk($sformatf("d%0d_busy", d),    busy[d],    held[d]);
        chk($sformatf("d%0d_p_data", d),  gpd, pd[d]);
        chk($sformatf("d%0d_m_data", d),  gmd, md[d]);
        chk($sformatf("d%0d_m_lane", d),  gml, ml[d]);
        chk($sformatf("d%0d_wcount", d),  gwc, nwords[d] % (1 << cw(d)));

        if (reset) begin
            held[d] = 0; ser[d] = 0; pd[d] = '0; md[d] = '0;
            ml[d] = 0; done[d] = 0; nwords[d] = 0;
        end else begin
            if (pv && p_ready[d]) begin
                nwords[d]++; held[d] = 0;
            end else if (mv && m_ready[d]) begin
                if (last) begin nwords[d]++; held[d] = 0; end
                else done[d]++;
            end
            if (s_valid[d] && sr) begin
                held[d] = 1; ser[d] = mode[d]; word[d] = s_data[d]; done[d] = 0;
                if (!mode[d]) pd[d] = s_data[d];
            end
        end
    endtask

    // Check both DUTs against the model for the current inputs, then clock once.
    task automatic step();
        #1;
        check_dut(0);
        check_dut(1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        mode = '0; s_valid = '0; p_ready = '0; m_ready = '0;
        s_data[0] = '0; s_data[1] = '0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [31:0] seqv;

    initial begin
        reset = 1'b1;
        idle_all();
        model_reset();
        @(posedge clock);
        #1;

        // reset state
        do_reset();
        chk("rst_wc0", {28'b0, wc0}, 0);
        chk("rst_busy", {62'b0, busy}, 0);
        chk("rst_pval", {62'b0, p_valid}, 0);
        chk("rst_mval", {62'b0, m_valid}, 0);

        // parallel, back-to-back
        mode[0] = 1'b0; p_ready[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = 32'hDEADBEEF;
        step();
        chk("par_pvalid", p_valid[0], 1);
        chk("par_lo", p_data0[15:0], 16'hBEEF);
        chk("par_hi", p_data0[31:16], 16'hDEAD);
        for (int i = 0; i < 3; i++) begin
            s_data[0] = $urandom;
            step();
            chk("par_sready", s_ready[0], 1);
        end
        s_valid[0] = 1'b0;
        step();
        chk("par_wc", wc0, 4);

        // serial, ascending lanes
        do_reset();
        mode[0] = 1'b1; m_ready[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = 32'h12345678;
        step();
        s_valid[0] = 1'b0;
        chk("ser_d0", m_data0, 16'h5678);
        chk("ser_l0", m_lane0, 0);
        chk("ser_last0", m_last[0], 0);
        chk("ser_srdy0", s_ready[0], 0);
        step();
        chk("ser_d1", m_data0, 16'h1234);
        chk("ser_l1", m_lane0, 1);
        chk("ser_last1", m_last[0], 1);
        chk("ser_srdy1", s_ready[0], 1);
        step();
        chk("ser_wc", wc0, 1);

        // serial, descending lanes on the 4 x 8 instance
        do_reset();
        mode[1] = 1'b1; m_ready[1] = 1'b1; s_valid[1] = 1'b1; s_data[1] = 32'hA1B2C3D4;
        step();
        s_valid[1] = 1'b0;
        seqv = 32'hA1B2C3D4;
        for (int i = 0; i < 4; i++) begin
            chk("msb_data", m_data1, seqv[31 - 8*i -: 8]);
            chk("msb_lane", m_lane1, 3 - i);
            chk("msb_last", m_last[1], (i == 3) ? 1 : 0);
            step();
        end
        chk("msb_wc", wc1, 1);

        // backpressure with mode toggling
        do_reset();
        mode[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = 32'hCAFE0123; m_ready[0] = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            mode[0] = ~mode[0];
            s_data[0] = $urandom;
            step();
            chk("bp_data", m_data0, 16'h0123);
            chk("bp_lane", m_lane0, 0);
            chk("bp_last", m_last[0], 0);
            chk("bp_valid", m_valid[0], 1);
            chk("bp_sready", s_ready[0], 0);
        end
        s_valid[0] = 1'b0; m_ready[0] = 1'b1;
        step();
        chk("bp_data_hi", m_data0, 16'hCAFE);
        chk("bp_last_hi", m_last[0], 1);
        step();
        chk("bp_wc", wc0, 1);
        chk("bp_busy", busy[0], 0);

        // reset in the middle of a serial word
        do_reset();
        mode[0] = 1'b1; m_ready[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = 32'h55AA33CC;
        step();
        s_valid[0] = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_mdata", m_data0, 0);
        chk("mid_mlane", m_lane0, 0);
        chk("mid_mvalid", m_valid[0], 0);
        chk("mid_busy", busy[0], 0);
        chk("mid_wc", wc0, 0);
        s_valid[0] = 1'b1; s_data[0] = 32'h0F0F7777;
        step();
        s_valid[0] = 1'b0;
        chk("mid_next_lane", m_lane0, 0);
        chk("mid_next_data", m_data0, 16'h7777);
        step();
        step();
        chk("mid_next_wc", wc0, 1);

        // counter wrap on the 4-bit counter
        do_reset();
        mode[0] = 1'b0; p_ready[0] = 1'b1; s_valid[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_data[0] = $urandom;
            step();
        end
        s_valid[0] = 1'b0;
        step();
        chk("wrap_wc", wc0, 1);

        // randomized traffic on both instances
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                s_valid[d] = ($urandom_range(0, 3) != 0);
                mode[d]    = $urandom_range(0, 1);
                p_ready[d] = ($urandom_range(0, 3) != 0);
                m_ready[d] = ($urandom_range(0, 3) != 0);
                s_data[d]  = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_lane_splitter.md
Name: stream_lane_splitter

Overview:
- Parametrised successor to the team's fixed 32-to-2x16 splitter.
- Accepts one wide word per valid/ready handshake and splits it into LANES lanes of LANE_WIDTH bits.
- Parallel mode: presents all lanes at once on a registered parallel port.
- Serial mode: emits the lanes one per handshake on a narrow stream port with lane index and last flag. Sits between wide ingress datapaths and lane-oriented consumers.

Parameters:
- LANE_WIDTH, 16: bits per lane.
- LANES, 2: lanes per input word; legal range 2..16.
- LSB_FIRST, 1: serial order. 1 = lane 0 (bits [LANE_WIDTH-1:0]) first; 0 = lane LANES-1 first.
- COUNT_WIDTH, 16: width of the completed-word counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = parallel, 1 = serial; sampled only on input accept.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept a word this cycle.
- s_data  in  LANES*LANE_WIDTH  input word.
- p_valid  out  1  parallel output valid.
- p_ready  in  1  parallel consumer ready.
- p_data  out  LANES*LANE_WIDTH  split lanes; lane i at [i*LANE_WIDTH +: LANE_WIDTH].
- m_valid  out  1  serial lane valid.
- m_ready  in  1  serial consumer ready.
- m_data  out  LANE_WIDTH  current serial lane.
- m_lane  out  clog2(LANES)  source lane index of m_data.
- m_last  out  1  final lane of the current word.
- word_count  out  COUNT_WIDTH  words fully delivered; wraps to 0.
- busy  out  1  a word is held (state != IDLE).

Behaviour:
- Reset:
  - state = IDLE.
  - p_valid, m_valid, m_last, busy = 0.
  - p_data, m_data, m_lane, word_count = 0.
  - Lane counter = 0.
  - Reset mid-word discards the held word with no partial completion.
- Accept: occurs when s_valid && s_ready. s_data is captured into the holding register and mode into the mode flop.
- FSM states: IDLE, PAR, SER.
  - IDLE: s_ready = 1. On accept, go to PAR (mode = 0) or SER (mode = 1).
  - PAR: p_valid = 1, p_data = held word. On p_ready the word completes.
  - SER: m_valid = 1.
    - m_data = held lane[sel], where sel = cnt if LSB_FIRST, else LANES-1-cnt.
    - m_lane = sel.
    - m_last = (cnt == LANES-1).
    - On m_ready && !m_last: cnt increments.
    - On m_ready && m_last: the word completes and cnt returns to 0.
- s_ready = IDLE, or (PAR && p_ready), or (SER && m_ready && m_last). This allows a new accept in the same cycle a word completes.
  - Sustained throughput: 1 word/cycle in parallel mode, 1 word per LANES cycles in serial mode.
- Completion with a simultaneous accept: go directly to the new word's state (PAR or SER); no IDLE bubble.
- Completion without an accept: go to IDLE.
- Latency: a word accepted at cycle N is visible on p_* or m_* at cycle N+1.
- Backpressure: while valid && !ready, data, lane, last and valid hold stable.
- Unused port: p_valid = 0 in serial mode; m_valid = 0 in parallel mode. The inactive port's data holds its last value.
- Mode changes while busy are ignored until the next accept.
- word_count increments by 1 on each completion (p_ready in PAR, or m_ready && m_last in SER) and wraps modulo 2^COUNT_WIDTH.
- p_ready and m_ready are ignored in any state where the corresponding port is not valid.

Decomposition:
- Shared package stream_split_pkg holds:
  - The state enum (IDLE, PAR, SER).
  - A clog2-based lane index width function.
  - Mode encoding constants MODE_PAR = 0 and MODE_SER = 1.
- One sub-module, stream_lane_select: combinational LANES:1 lane mux taking the held word, cnt and LSB_FIRST, and producing m_data and m_lane.
  - Reusable by the future lane merger.
- FSM, holding register and counters stay in the top module.

Test Plan:
- Parallel (LANES=2, W=16): reset, mode=0, s_data=0xDEADBEEF, p_ready=1.
  - Cycle+1: p_valid=1, p_data[15:0]=0xBEEF, p_data[31:16]=0xDEAD.
  - s_ready stays 1; 4 back-to-back words give word_count=4 with no bubbles.
- Serial, LSB_FIRST=1: mode=1, s_data=0x12345678, m_ready=1.
  - Cycle+1: m_data=0x5678, m_lane=0, m_last=0, s_ready=0.
  - Cycle+2: m_data=0x1234, m_lane=1, m_last=1, s_ready=1. word_count then reads 1.
- Serial, LSB_FIRST=0, LANES=4, W=8: s_data=0xA1B2C3D4.
  - m_data sequence is 0xA1, 0xB2, 0xC3, 0xD4 with m_lane sequence 3, 2, 1, 0; m_last only on 0xD4.
- Backpressure and mode change: in SER, hold m_ready=0 for 3 cycles and toggle mode.
  - m_data, m_lane, m_last and m_valid stay constant; no accept (s_ready=0); the word still finishes serially.
- Reset mid-word: assert reset after lane 0 of a serial word.
  - Next cycle: all outputs 0 and state IDLE. The next word starts at lane 0, and word_count is unchanged by the aborted word (0).
- Counter wrap: COUNT_WIDTH=4, 17 parallel words delivered -> word_count=1.
